// File: rtl/tlc_pkg.sv
// tlc_pkg: shared direction codes, lamp encodings, phase enum and lamp-word helper.
// Fields of the 12-bit lamp word: [11:9]=N, [8:6]=E, [5:3]=S, [2:0]=W; each {green,yellow,red}.
package tlc_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    // Demand bits are ordered N..W from MSB down, so direction d lives at bit 3-d.
    function automatic logic [1:0] dir_bit(input logic [1:0] d);
        return 2'd3 - d;
    endfunction

    // Builds a lamp word with `lamp` on direction d and red everywhere else.
    function automatic logic [11:0] lamp_word(input logic [1:0] d, input logic [2:0] lamp);
        logic [11:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            w[3*(3-i) +: 3] = (2'(i) == d) ? lamp : RED;
        return w;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// tlc_rr_arbiter: combinational pick of the next green direction.
// Ports: i_req (N,E,S,W demand, MSB=N), i_cur_dir (current owner), i_emg_valid/i_emg_dir
// (pre-emption override), o_next_dir (chosen direction).
module tlc_rr_arbiter
    import tlc_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_cur_dir,
    input  logic       i_emg_valid,
    input  logic [1:0] i_emg_dir,
    output logic [1:0] o_next_dir
);

    logic [1:0] w_rr;
    logic [1:0] w_cand;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requesting direction after cur_dir wins; cur_dir is the fallback either
    // when only it requests or when nothing requests.
    always_comb begin
        w_rr   = i_cur_dir;
        w_cand = i_cur_dir;
        for (int k = 3; k >= 1; k--) begin
            w_cand = i_cur_dir + 2'(k);
            if (i_req[dir_bit(w_cand)])
                w_rr = w_cand;
        end
    end

    assign o_next_dir = i_emg_valid ? i_emg_dir : w_rr;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: actuated four-way GREEN->YELLOW->ALL-RED scheduler with emergency pre-emption.
// Ports: clk, rst (async, active-high), tick (timebase strobe), req[3:0] (N,E,S,W demand),
// emg_valid/emg_dir (pre-emption), emg_ack (grant pulse), lightout[11:0] (lamp word),
// cur_dir[1:0] (phase owner), phase[1:0] (0=ALLRED,1=GREEN,2=YELLOW). All outputs registered.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int GREEN_MIN = 20,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 8,
    parameter int ALLRED_T  = 2,
    parameter int TW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [3:0]  req,
    input  logic        emg_valid,
    input  logic [1:0]  emg_dir,
    output logic        emg_ack,
    output logic [11:0] lightout,
    output logic [1:0]  cur_dir,
    output logic [1:0]  phase
);

    localparam logic [TW-1:0] ONE       = TW'(1);
    localparam logic [TW-1:0] GMIN_M1   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_M1   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] GMAX      = TW'(GREEN_MAX);
    localparam logic [TW-1:0] YELLOW_M1 = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_M1 = TW'(ALLRED_T - 1);

    phase_t        r_phase, w_phase;
    logic [1:0]    r_dir, w_dir;
    logic [TW-1:0] r_timer, w_timer;
    logic [TW-1:0] r_gcnt, w_gcnt;
    logic [11:0]   r_light, w_light;
    logic          r_ack, w_ack;
    logic          r_emg_done;
    logic [1:0]    w_arb;
    logic          w_own, w_other, w_emg_same, w_emg_diff, w_yel_go;

    tlc_rr_arbiter u_arb (
        .i_req       (req),
        .i_cur_dir   (r_dir),
        .i_emg_valid (emg_valid),
        .i_emg_dir   (emg_dir),
        .o_next_dir  (w_arb)
    );

    assign w_own      = req[dir_bit(r_dir)];
    assign w_other    = |(req & ~(4'b1000 >> r_dir));
    assign w_emg_same = emg_valid && (emg_dir == r_dir);
    assign w_emg_diff = emg_valid && (emg_dir != r_dir);
    // Gap-out and max-out both compare the count before this tick's increment.
    assign w_yel_go   = tick && w_other && (((r_gcnt >= GMIN_M1) && !w_own) || (r_gcnt >= GMAX_M1));

    always_comb begin
        w_phase = r_phase;
        w_dir   = r_dir;
        w_timer = r_timer;
        w_gcnt  = r_gcnt;
        w_ack   = 1'b0;
        case (r_phase)
            PH_ALLRED: begin
                if (tick && r_timer == '0) begin
                    w_phase = PH_GREEN;
                    w_dir   = w_arb;
                    w_gcnt  = '0;
                    w_ack   = emg_valid && !r_emg_done;
                end else if (tick) begin
                    w_timer = r_timer - ONE;
                end
            end
            PH_GREEN: begin
                if (tick && r_gcnt != GMAX)
                    w_gcnt = r_gcnt + ONE;
                // Emergency priority: another direction forces yellow without a tick;
                // the current direction pins green and suppresses gap/max-out.
                if (w_emg_diff) begin
                    w_phase = PH_YELLOW;
                    w_timer = YELLOW_M1;
                end else if (w_emg_same) begin
                    w_ack = !r_emg_done;
                end else if (w_yel_go) begin
                    w_phase = PH_YELLOW;
                    w_timer = YELLOW_M1;
                end
            end
            PH_YELLOW: begin
                if (tick && r_timer == '0) begin
                    w_phase = PH_ALLRED;
                    w_timer = ALLRED_M1;
                end else if (tick) begin
                    w_timer = r_timer - ONE;
                end
            end
            default: w_phase = PH_ALLRED;
        endcase
        w_light = lamp_word(w_dir, (w_phase == PH_GREEN) ? GRN : (w_phase == PH_YELLOW) ? YEL : RED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= PH_ALLRED;
            r_dir      <= DIR_N;
            r_timer    <= ALLRED_M1;
            r_gcnt     <= '0;
            r_light    <= 12'b001_001_001_001;
            r_ack      <= 1'b0;
            r_emg_done <= 1'b0;
        end else begin
            r_phase    <= w_phase;
            r_dir      <= w_dir;
            r_timer    <= w_timer;
            r_gcnt     <= w_gcnt;
            r_light    <= w_light;
            r_ack      <= w_ack;
            // Re-arms the acknowledge only once emg_valid has been seen low.
            r_emg_done <= emg_valid && (r_emg_done || w_ack);
        end
    end

    assign emg_ack  = r_ack;
    assign lightout = r_light;
    assign cur_dir  = r_dir;
    assign phase    = r_phase;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: directed self-checking bench for tlc_phase_scheduler.
module tb_tlc_phase_scheduler;

    localparam logic [11:0] L_AR = 12'b001_001_001_001;
    localparam logic [11:0] L_NG = 12'b100_001_001_001;
    localparam logic [11:0] L_NY = 12'b010_001_001_001;
    localparam logic [11:0] L_EG = 12'b001_100_001_001;
    localparam logic [11:0] L_EY = 12'b001_010_001_001;
    localparam logic [11:0] L_SG = 12'b001_001_100_001;
    localparam logic [11:0] L_SY = 12'b001_001_010_001;
    localparam logic [11:0] L_WG = 12'b001_001_001_100;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic        emg_valid;
    logic [1:0]  emg_dir;
    logic        emg_ack;
    logic [11:0] lightout;
    logic [1:0]  cur_dir;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_errors = 0;

    tlc_phase_scheduler #(
        .GREEN_MIN (3),
        .GREEN_MAX (6),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .TW        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .emg_valid (emg_valid),
        .emg_dir   (emg_dir),
        .emg_ack   (emg_ack),
        .lightout  (lightout),
        .cur_dir   (cur_dir),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the DUT in reset for one cycle; the next rising edge ends all-red.
    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        emg_valid = 1'b0;
        emg_dir = 2'd0;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b1;
        req = 4'b0000;
        emg_valid = 1'b0;
        emg_dir = 2'd0;
        cyc(2);
        check("rst_light", 32'(lightout), 32'(L_AR));
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_dir", 32'(cur_dir), 32'd0);
        check("rst_ack", 32'(emg_ack), 32'd0);

        // Idle rest on N.
        rst = 1'b0;
        cyc(1);
        check("idle_ng", 32'(lightout), 32'(L_NG));
        check("idle_phase", 32'(phase), 32'd1);
        cyc(8);
        check("idle_rest", 32'(lightout), 32'(L_NG));

        // Max-out: N holds its own demand while S waits.
        do_reset(4'b1000);
        cyc(1);
        check("max_e0", 32'(lightout), 32'(L_NG));
        req = 4'b1010;
        cyc(5);
        check("max_e5", 32'(lightout), 32'(L_NG));
        cyc(1);
        check("max_y1", 32'(lightout), 32'(L_NY));
        cyc(1);
        check("max_y2", 32'(lightout), 32'(L_NY));
        cyc(1);
        check("max_ar", 32'(lightout), 32'(L_AR));
        cyc(1);
        check("max_sg", 32'(lightout), 32'(L_SG));
        check("max_dir", 32'(cur_dir), 32'd2);

        // Gap-out: N demand drops, S waiting.
        do_reset(4'b1000);
        cyc(1);
        req = 4'b0010;
        cyc(2);
        check("gap_e2", 32'(lightout), 32'(L_NG));
        cyc(1);
        check("gap_y", 32'(lightout), 32'(L_NY));
        check("gap_phase", 32'(phase), 32'd2);

        // Round-robin from E skips idle S and picks W.
        do_reset(4'b0100);
        cyc(1);
        check("rr_eg", 32'(lightout), 32'(L_EG));
        req = 4'b1001;
        cyc(3);
        check("rr_ey", 32'(lightout), 32'(L_EY));
        cyc(2);
        check("rr_ar", 32'(lightout), 32'(L_AR));
        check("rr_ar_dir", 32'(cur_dir), 32'd1);
        cyc(1);
        check("rr_wg", 32'(lightout), 32'(L_WG));
        check("rr_dir", 32'(cur_dir), 32'd3);

        // Pre-emption for S while N green at count 0.
        do_reset(4'b1000);
        cyc(1);
        emg_valid = 1'b1;
        emg_dir = 2'd2;
        cyc(1);
        check("pe_ny", 32'(lightout), 32'(L_NY));
        check("pe_ack0", 32'(emg_ack), 32'd0);
        cyc(2);
        check("pe_ar", 32'(lightout), 32'(L_AR));
        check("pe_ack1", 32'(emg_ack), 32'd0);
        cyc(1);
        check("pe_sg", 32'(lightout), 32'(L_SG));
        check("pe_ack", 32'(emg_ack), 32'd1);
        req = 4'b1111;
        cyc(1);
        check("pe_ack_once", 32'(emg_ack), 32'd0);
        cyc(8);
        check("pe_hold", 32'(lightout), 32'(L_SG));
        check("pe_hold_ack", 32'(emg_ack), 32'd0);

        // Withdrawal: accumulated count is past max, so yellow follows at once.
        emg_valid = 1'b0;
        cyc(1);
        check("wd_sy", 32'(lightout), 32'(L_SY));

        // Asynchronous reset in the middle of yellow.
        #2 rst = 1'b1;
        #1;
        check("arst_light", 32'(lightout), 32'(L_AR));
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_dir", 32'(cur_dir), 32'd0);
        cyc(1);

        // Emergency matching the green direction; re-arm after a low cycle.
        do_reset(4'b1000);
        cyc(1);
        emg_valid = 1'b1;
        emg_dir = 2'd0;
        cyc(1);
        check("same_ack", 32'(emg_ack), 32'd1);
        check("same_ng", 32'(lightout), 32'(L_NG));
        cyc(1);
        check("same_ack_lo", 32'(emg_ack), 32'd0);
        emg_valid = 1'b0;
        cyc(1);
        emg_valid = 1'b1;
        cyc(1);
        check("same_rearm", 32'(emg_ack), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Actuated four-way intersection scheduler: arbitrates vehicle demand and emergency pre-emption among the North, East, South and West approaches, and sequences GREEN -> YELLOW -> ALL-RED phases with cycle-accurate, tick-based timers. Its output is the 12-bit lamp word used across the traffic-light designs: north in the MSBs, then east, south, west. Each direction is 3 bits {green, yellow, red}. The block replaces `$time`-based real timers with synthesizable counters and sits between the sensor/pre-emption inputs and the lamp drivers.

## Interface
- `GREEN_MIN`, 20, minimum green duration in ticks (>=1)
- `GREEN_MAX`, 60, maximum green duration in ticks when other demand exists (>=`GREEN_MIN`)
- `YELLOW_T`, 8, yellow duration in ticks (>=1)
- `ALLRED_T`, 2, all-red clearance in ticks (>=1)
- `TW`, 8, timer width; must hold `GREEN_MAX`
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous and active-high
- `tick` in 1: one-cycle timebase strobe; all timers advance only on `tick`
- `req` in 4: level vehicle demand, bit 3=N, 2=E, 1=S, 0=W
- `emg_valid` in 1: emergency pre-emption request, level, held by requester
- `emg_dir` in 2: emergency direction, 0=N, 1=E, 2=S, 3=W; sampled while `emg_valid`=1
- `emg_ack` out 1: one-cycle pulse when green is first granted to `emg_dir` under pre-emption
- `lightout` out 12: lamp word, registered
- `cur_dir` out 2: direction currently owning the phase
- `phase` out 2: 0=ALLRED, 1=GREEN, 2=YELLOW

## Operation
- Reset values:
  - `phase`=ALLRED, `cur_dir`=N
  - timer=`ALLRED_T`-1, green count=0
  - `lightout`=001_001_001_001
  - `emg_ack`=0
- Lamps:
  - GREEN: `cur_dir` field=100, all other fields=001.
  - YELLOW: `cur_dir` field=010, all other fields=001.
  - ALLRED: all fields=001.
- ALLRED: on `tick` with timer==0, select the next direction and enter GREEN with green count=0.
  - If `emg_valid`=1, the next direction is `emg_dir`.
  - Otherwise, round-robin search `cur_dir`+1, +2, +3, then `cur_dir` (mod 4); the first direction with its `req` bit set wins.
  - If no `req` bit is set, the next direction is `cur_dir`.
- GREEN: each `tick` increments green count, saturating at `GREEN_MAX`. `other` = any `req` bit except the `cur_dir` bit.
  - Emergency for a different direction: go to YELLOW on the next clock edge, no tick needed; ignores `GREEN_MIN`.
  - Emergency for `cur_dir`: hold GREEN regardless of count.
  - Otherwise, on `tick`, go to YELLOW if `other` && (count >= `GREEN_MIN`-1 && !`req[cur_dir]`) — gap-out.
  - Otherwise, on `tick`, go to YELLOW if `other` && count >= `GREEN_MAX`-1 — max-out.
  - No `other` demand and no emergency: rest in GREEN indefinitely.
- YELLOW: load timer=`YELLOW_T`-1; on `tick` with timer==0, go to ALLRED and load timer=`ALLRED_T`-1. Otherwise decrement on `tick`. Emergency does not shorten yellow or all-red.
- `emg_ack`:
  - Pulses on the edge entering GREEN with pre-emption selected.
  - Pulses on the first edge an emergency matches an already-green `cur_dir`.
  - Does not pulse again until `emg_valid` has been low for at least one cycle.
- Emergency withdrawal: after `emg_valid` falls, normal GREEN rules resume using the accumulated count.
- Simultaneous events: `rst` dominates everything; emergency beats gap-out and max-out in the same cycle; a `req` change in the deciding cycle is honoured.

## Timing
- All outputs are registered. Outputs change on the same edge as the state transition; there is no extra output stage.
- Tick-driven transitions take effect on the edge where `tick`=1.
- Emergency exit from GREEN takes effect on the first edge where `emg_valid`=1 is sampled.
- Phase lengths, with `tick` every cycle:
  - Yellow lasts exactly `YELLOW_T` cycles.
  - All-red lasts exactly `ALLRED_T` cycles.
  - Green lasts between `GREEN_MIN` and `GREEN_MAX` cycles, unless pre-empted or resting.
- Worst-case pre-emption latency from `emg_valid` to green = 1 + `YELLOW_T` + `ALLRED_T` ticks.
- Reset asserted mid-phase forces the reset values immediately (asynchronously). Release is synchronous to `clk`; the first tick after release counts down the all-red timer.

## Structure
- Shared package `tlc_pkg`:
  - direction codes N/E/S/W
  - 3-bit lamp constants GRN=100, YEL=010, RED=001
  - `phase` enum ALLRED/GREEN/YELLOW
  - helper that places a lamp into the 12-bit word by direction
- One sub-module, `tlc_rr_arbiter`: combinational 4-way round-robin pick given `req`, `cur_dir`, and the emergency override. Outputs the next direction. Expected size is about 40 lines.
- The top level holds the FSM, timer, green counter and `emg_ack` edge logic.

## Test plan
All scenarios use `GREEN_MIN`=3, `GREEN_MAX`=6, `YELLOW_T`=2, `ALLRED_T`=1, and `tick` every cycle.
- Reset, then `req`=0000: after 1 cycle of all-red, `lightout`=100_001_001_001 (N green) and rests with no further change.
- N green with `req`=1000, then set `req`=1010 (S waiting): max-out after 6 green cycles; 2 cycles of 010_001_001_001; 1 cycle all-red; then 001_001_100_001.
- N green with `req`=0010 (N gap): yellow starts after exactly 3 green cycles.
- Round-robin: `cur_dir`=E, all-red end, `req`=1001: W is selected (E+1=S idle, E+2=W); `lightout`=001_001_001_100.
- Pre-emption: N green at count 0, `emg_valid`=1, `emg_dir`=2 → yellow next edge, S green after 3 more cycles, `emg_ack` a single pulse; the hold persists while valid even with `req`=1111.
- Assert `rst` during YELLOW → `lightout`=001_001_001_001, `phase`=0, `cur_dir`=0 with no clock edge required.
